// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op codes, sequencer states and constants for the HI/LO mul/div unit
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MADD,
        MD_MADDU,
        MD_MSUB,
        MD_MSUBU
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } md_state_t;

    localparam int MD_DIV_CYCLES = 32;

    function automatic logic is_div(md_op_t op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_signed(md_op_t op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage <-> mul/div sequencer bundle
//   master (execute stage): drives start/op/src_a/src_b/hi_in/lo_in/flush, sees stall/busy/hilo_we/hi_out/lo_out
//   slave  (sequencer):     the reverse
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, src_a, src_b, hi_in, lo_in, flush,
        input  stall, busy, hilo_we, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, hi_in, lo_in, flush,
        output stall, busy, hilo_we, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// muldiv_ctrl_div_iter: unsigned restoring divider, one quotient bit per step
//   clk             clock
//   load            capture dividend/divisor and clear the partial remainder
//   step            perform one shift/trial-subtract iteration
//   dividend/divisor  32-bit unsigned operands
//   quo/rem         quotient and remainder, valid after 32 steps
module muldiv_ctrl_div_iter (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);
    // sr = {partial remainder, dividend bits still to shift in / quotient bits shifted out}
    logic [63:0] sr;
    logic [31:0] dvs;
    logic [32:0] part;
    logic [31:0] diff;
    logic        ge;

    // part is the shifted remainder with the next dividend bit; when it fits, the
    // difference is below the divisor so 32 bits hold it exactly
    assign part = sr[63:31];
    assign ge   = part >= {1'b0, dvs};
    assign diff = part[31:0] - dvs;

    always_ff @(posedge clk) begin
        if (load) begin
            sr  <= {32'd0, dividend};
            dvs <= divisor;
        end else if (step) begin
            sr <= ge ? {diff, sr[30:0], 1'b1} : {sr[62:0], 1'b0};
        end
    end

    assign quo = sr[31:0];
    assign rem = sr[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO multiply/divide sequencer beside the execute stage
//   clk    clock
//   reset  synchronous active-high reset
//   bus    muldiv_ctrl_if.slave: start/op/src_a/src_b/hi_in/lo_in/flush in,
//          stall/busy/hilo_we/hi_out/lo_out out
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input logic          clk,
    input logic          reset,
    muldiv_ctrl_if.slave bus
);
    md_state_t   state, state_n;
    logic [4:0]  cnt;
    md_op_t      op_q;
    logic [31:0] abs_a, abs_b, a_abs, b_abs;
    logic        neg_a, neg_b, sgn, accept;
    logic [63:0] acc, prod_u, prod, mul_res, div_res;
    logic [31:0] quo, rem, hi_q, lo_q;

    assign accept = state == ST_IDLE && bus.start && !bus.flush;
    assign sgn    = is_signed(bus.op);
    assign a_abs  = sgn && bus.src_a[31] ? -bus.src_a : bus.src_a;
    assign b_abs  = sgn && bus.src_b[31] ? -bus.src_b : bus.src_b;

    muldiv_ctrl_div_iter u_div (
        .clk     (clk),
        .load    (accept),
        .step    (state == ST_DIV),
        .dividend(a_abs),
        .divisor (b_abs),
        .quo     (quo),
        .rem     (rem)
    );

    // magnitudes are multiplied unsigned, then the sign is restored before accumulating
    assign prod_u  = {32'd0, abs_a} * {32'd0, abs_b};
    assign prod    = neg_a ^ neg_b ? -prod_u : prod_u;
    assign mul_res = op_q inside {MD_MADD, MD_MADDU} ? acc + prod :
                     op_q inside {MD_MSUB, MD_MSUBU} ? acc - prod : prod;
    // quotient negated on sign mismatch, remainder follows the dividend
    assign div_res = {neg_a ? -rem : rem, neg_a ^ neg_b ? -quo : quo};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = accept ? (is_div(bus.op) ? ST_DIV : ST_MUL) : ST_IDLE;
            ST_MUL:  state_n = cnt == '0 ? ST_DONE : ST_MUL;
            ST_DIV:  state_n = cnt == '0 ? ST_FIX : ST_DIV;
            ST_FIX:  state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
        if (bus.flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= MD_MULT;
            abs_a <= '0;
            abs_b <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            acc   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                abs_a <= a_abs;
                abs_b <= b_abs;
                neg_a <= sgn && bus.src_a[31];
                neg_b <= sgn && bus.src_b[31];
                acc   <= {bus.hi_in, bus.lo_in};
                cnt   <= is_div(bus.op) ? 5'(MD_DIV_CYCLES - 1) : 5'(MUL_LAT - 1);
            end else if ((state == ST_MUL || state == ST_DIV) && cnt != '0) begin
                cnt <= cnt - 5'd1;
            end
            // result register loads on entry to DONE and holds afterwards
            if (state_n == ST_DONE) {hi_q, lo_q} <= state == ST_FIX ? div_res : mul_res;
        end
    end

    assign bus.stall   = (bus.start && state == ST_IDLE) || state inside {ST_MUL, ST_DIV, ST_FIX};
    assign bus.busy    = state != ST_IDLE;
    assign bus.hilo_we = state == ST_DONE && !bus.flush;
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed + random scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = MD_DIV_CYCLES + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_ctrl_if dif ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dif.slave)
    );

    int passed = 0;
    int total = 0;
    logic [63:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(md_op_t o, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] h, logic [31:0] l);
        logic signed [63:0] sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        logic [63:0] up = {32'd0, a} * {32'd0, b};
        logic [63:0] acc = {h, l};
        logic [31:0] q, r;
        case (o)
            MD_MULT:  return sp;
            MD_MULTU: return up;
            MD_MADD:  return acc + sp;
            MD_MADDU: return acc + up;
            MD_MSUB:  return acc - sp;
            MD_MSUBU: return acc - up;
            MD_DIV: begin
                if (b == 0) begin
                    q = a[31] ? 32'd1 : 32'hFFFFFFFF;
                    r = a;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
                return {r, q};
            end
            default: return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
    endfunction

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input bit push, input logic [63:0] exp);
        dif.start = 1'b1;
        dif.op    = o;
        dif.src_a = a;
        dif.src_b = b;
        dif.hi_in = h;
        dif.lo_in = l;
        if (push) sb.push_back(exp);
    endtask

    // called at the falling edge of the start cycle; returns inside the DONE cycle
    task automatic wait_done(input int lat, input string tag);
        int n = 0;
        logic [63:0] e;
        #1;
        while (dif.hilo_we !== 1'b1 && n < 80) begin
            chk({tag, " stall"}, 64'(dif.stall), 64'd1);
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        e = sb.size() != 0 ? sb.pop_front() : '1;
        chk({tag, " hi"}, 64'(dif.hi_out), 64'(e[63:32]));
        chk({tag, " lo"}, 64'(dif.lo_out), 64'(e[31:0]));
        chk({tag, " stall@done"}, 64'(dif.stall), 64'd0);
    endtask

    initial begin
        md_op_t o;
        logic [31:0] a, b, h, l;
        bit seen;
        dif.start = 1'b0;
        dif.op    = MD_MULT;
        dif.src_a = '0;
        dif.src_b = '0;
        dif.hi_in = '0;
        dif.lo_in = '0;
        dif.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", 64'(dif.busy), 64'd0);
        chk("rst stall", 64'(dif.stall), 64'd0);
        chk("rst we", 64'(dif.hilo_we), 64'd0);
        chk("rst hi", 64'(dif.hi_out), 64'd0);
        chk("rst lo", 64'(dif.lo_out), 64'd0);
        reset = 1'b0;

        @(negedge clk);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 0, 0, 1, 64'h00000001_FFFFFFFE);
        wait_done(MUL_LAT + 1, "multu");
        dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("hold hi", 64'(dif.hi_out), 64'h1);
        chk("idle busy", 64'(dif.busy), 64'd0);

        @(negedge clk);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 64'hFFFFFFFF_FFFFFFFD);
        wait_done(DIV_LAT, "div -7/2");
        dif.start = 1'b0;

        @(negedge clk);
        issue(MD_DIVU, 32'd100, 32'd7, 0, 0, 1, {32'd2, 32'd14});
        wait_done(DIV_LAT, "divu 100/7");
        dif.start = 1'b0;

        @(negedge clk);
        issue(MD_DIVU, 32'd100, 32'd0, 0, 0, 1, {32'd100, 32'hFFFFFFFF});
        wait_done(DIV_LAT, "divu /0");
        dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("div0 idle@35", 64'(dif.busy), 64'd0);

        @(negedge clk);
        issue(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 1, 64'h00000001_00000000);
        wait_done(MUL_LAT + 1, "maddu");
        dif.start = 1'b0;

        @(negedge clk);
        issue(MD_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 1, 64'hFFFFFFFF_FFFFFFFF);
        wait_done(MUL_LAT + 1, "msub");
        dif.start = 1'b0;

        for (int i = 0; i < 8; i++) begin
            o = md_op_t'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            h = $urandom;
            l = $urandom;
            if (o == MD_DIV && b == 32'hFFFFFFFF) b = 32'd3;
            @(negedge clk);
            issue(o, a, b, h, l, 1, model(o, a, b, h, l));
            wait_done(is_div(o) ? DIV_LAT : MUL_LAT + 1, $sformatf("rand%0d op%0d", i, o));
            dif.start = 1'b0;
        end

        @(negedge clk);
        issue(MD_DIV, 32'd50, 32'd3, 0, 0, 0, '0);
        repeat (10) @(negedge clk);
        dif.flush = 1'b1;
        dif.start = 1'b0;
        #1;
        chk("flush div we", 64'(dif.hilo_we), 64'd0);
        chk("flush div busy@10", 64'(dif.busy), 64'd1);
        @(negedge clk);
        dif.flush = 1'b0;
        #1;
        chk("flush div busy@11", 64'(dif.busy), 64'd0);
        chk("flush div stall@11", 64'(dif.stall), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (dif.hilo_we === 1'b1) seen = 1'b1;
        end
        chk("flush div no strobe", 64'(seen), 64'd0);

        @(negedge clk);
        issue(MD_MULTU, 32'd3, 32'd5, 0, 0, 0, '0);
        repeat (MUL_LAT + 1) @(negedge clk);
        dif.flush = 1'b1;
        dif.start = 1'b0;
        #1;
        chk("flush done we", 64'(dif.hilo_we), 64'd0);
        chk("flush done busy", 64'(dif.busy), 64'd1);
        @(negedge clk);
        dif.flush = 1'b0;
        #1;
        chk("flush done idle", 64'(dif.busy), 64'd0);
        chk("flush done we after", 64'(dif.hilo_we), 64'd0);

        @(negedge clk);
        issue(MD_MULT, 32'd7, 32'd9, 0, 0, 0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("rst mid busy", 64'(dif.busy), 64'd0);
        chk("rst mid stall", 64'(dif.stall), 64'd0);
        chk("rst mid we", 64'(dif.hilo_we), 64'd0);
        chk("rst mid hi", 64'(dif.hi_out), 64'd0);
        chk("rst mid lo", 64'(dif.lo_out), 64'd0);
        reset = 1'b0;

        @(negedge clk);
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, 1, 64'hFFFFFFFF_FFFFFFF1);
        wait_done(MUL_LAT + 1, "b2b mult");
        issue(MD_DIV, 32'd1000, 32'hFFFFFFF9, 0, 0, 1, {32'd6, 32'hFFFFFF72});
        @(negedge clk);
        wait_done(DIV_LAT, "b2b div");
        dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
